// File: rtl/uart_host_interface_if.sv
//------------------------------------------------------------------------------
// Module  : uart_host_interface_if
// Brief   : Host bus control signals (chip select, address, direction).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_host_interface_if;
    logic       chip_sel_n;
    logic [2:0] address;
    logic       read_write;

    modport master (output chip_sel_n, address, read_write);
    modport slave  (input  chip_sel_n, address, read_write);
endinterface

`default_nettype wire

// File: rtl/uart_host_interface.sv
//------------------------------------------------------------------------------
// Module  : uart_host_interface
// Brief   : UART host register file, FIFO access and prioritised interrupts.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_host_interface #(
    parameter logic [15:0] RST_DIVISOR   = 16'd26,
    parameter logic [7:0]  RST_CTR       = 8'h03,
    parameter logic [5:0]  RST_THRESHOLD = 6'd0
) (
    input  wire logic               clk_i,
    input  wire logic               rst_n_i,
    uart_host_interface_if.slave    host,
    inout  wire       [7:0]         data_io,
    output logic                    ireq_n_o,
    output logic      [15:0]        divisor_o,
    output logic      [1:0]         data_width_o,
    output logic                    stop_bits_o,
    output logic      [1:0]         parity_mode_o,
    output logic                    rx_stream_o,
    output logic                    tx_stream_o,
    output logic      [5:0]         threshold_o,
    output logic      [7:0]         tx_data_o,
    output logic                    tx_fifo_write_o,
    output logic                    rx_fifo_read_o,
    input  wire logic [7:0]         data_rx_i,
    input  wire logic               rx_fifo_empty_i,
    input  wire logic               rx_fifo_full_i,
    input  wire logic               tx_fifo_empty_i,
    input  wire logic               tx_fifo_full_i,
    input  wire logic               rx_idle_i,
    input  wire logic               tx_idle_i,
    input  wire logic               tx_done_i,
    input  wire logic               overrun_error_i,
    input  wire logic               frame_error_i,
    input  wire logic               parity_error_i
);

    localparam logic [2:0] c_ADDR_STR  = 3'd0;
    localparam logic [2:0] c_ADDR_LDVR = 3'd1;
    localparam logic [2:0] c_ADDR_UDVR = 3'd2;
    localparam logic [2:0] c_ADDR_FSR  = 3'd3;
    localparam logic [2:0] c_ADDR_CTR  = 3'd4;
    localparam logic [2:0] c_ADDR_ISR  = 3'd5;
    localparam logic [2:0] c_ADDR_RXR  = 3'd6;
    localparam logic [2:0] c_ADDR_TXR  = 3'd7;

    localparam logic [2:0] c_ID_NONE = 3'b000;
    localparam logic [2:0] c_ID_ERR  = 3'b001;
    localparam logic [2:0] c_ID_RXD  = 3'b010;
    localparam logic [2:0] c_ID_TXD  = 3'b011;

    logic       r_cs_n_prev;
    logic [7:0] r_ldvr;
    logic [7:0] r_udvr;
    logic [6:0] r_ctr;
    logic [5:0] r_thr;
    logic [2:0] r_ien;
    logic       r_err_p;
    logic       r_txd_p;
    logic       r_tx_wr_err;
    logic       r_rx_rd_err;
    logic       r_ireq_n;

    logic       w_accept;
    logic       w_rd;
    logic       w_wr;
    logic       w_drive;
    logic [7:0] w_rdata;
    logic [2:0] w_id;
    logic       w_wr_txr;
    logic       w_rd_rxr;
    logic       w_rd_str;
    logic       w_tx_ovf;
    logic       w_rx_unf;
    logic       w_ack;
    logic       w_err_evt;

    // Reset value 0 means "selected": a select held across reset release
    // must first be dropped before it can start a transaction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cs_n_prev <= 1'b0;
        end else begin
            r_cs_n_prev <= host.chip_sel_n;
        end
    end

    assign w_accept = !host.chip_sel_n && r_cs_n_prev;
    assign w_rd     = w_accept &&  host.read_write;
    assign w_wr     = w_accept && !host.read_write;
    assign w_drive  = !host.chip_sel_n && host.read_write;

    assign w_wr_txr = w_wr && (host.address == c_ADDR_TXR);
    assign w_rd_rxr = w_rd && (host.address == c_ADDR_RXR);
    assign w_rd_str = w_rd && (host.address == c_ADDR_STR);
    assign w_tx_ovf = w_wr_txr && tx_fifo_full_i;
    assign w_rx_unf = w_rd_rxr && rx_fifo_empty_i;
    assign w_ack    = w_wr && (host.address == c_ADDR_ISR) && data_io[0];
    assign w_err_evt = overrun_error_i || frame_error_i || parity_error_i;

    assign tx_fifo_write_o = w_wr_txr && !tx_fifo_full_i;
    assign rx_fifo_read_o  = w_rd_rxr && !rx_fifo_empty_i;
    assign tx_data_o       = data_io;

    assign data_io = w_drive ? w_rdata : 8'hzz;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ldvr <= RST_DIVISOR[7:0];
            r_udvr <= RST_DIVISOR[15:8];
            r_ctr  <= RST_CTR[6:0];
            r_thr  <= RST_THRESHOLD;
            r_ien  <= 3'b000;
        end else if (w_wr) begin
            case (host.address)
                c_ADDR_LDVR: r_ldvr <= data_io;
                c_ADDR_UDVR: r_udvr <= data_io;
                c_ADDR_FSR:  r_thr  <= data_io[5:0];
                c_ADDR_CTR:  r_ctr  <= data_io[6:0];
                c_ADDR_ISR:  r_ien  <= data_io[6:4];
                default:     ;
            endcase
        end
    end

    // Sticky access errors: a new error in the clearing cycle takes priority.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_wr_err <= 1'b0;
            r_rx_rd_err <= 1'b0;
        end else begin
            r_tx_wr_err <= w_tx_ovf || (r_tx_wr_err && !w_rd_str);
            r_rx_rd_err <= w_rx_unf || (r_rx_rd_err && !w_rd_str);
        end
    end

    always_comb begin
        w_id = c_ID_NONE;
        if (r_ien[2] && r_err_p) begin
            w_id = c_ID_ERR;
        end else if (r_ien[1] && !rx_fifo_empty_i) begin
            w_id = c_ID_RXD;
        end else if (r_ien[0] && r_txd_p) begin
            w_id = c_ID_TXD;
        end
    end

    // Ack clears only the source currently shown; a fresh pulse wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_p  <= 1'b0;
            r_txd_p  <= 1'b0;
            r_ireq_n <= 1'b1;
        end else begin
            r_err_p  <= w_err_evt || (r_err_p && !(w_ack && (w_id == c_ID_ERR)));
            r_txd_p  <= tx_done_i || (r_txd_p && !(w_ack && (w_id == c_ID_TXD)));
            r_ireq_n <= (w_id == c_ID_NONE);
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (host.address)
            c_ADDR_STR:  w_rdata = {tx_idle_i, rx_idle_i, tx_fifo_full_i, tx_fifo_empty_i,
                                    rx_fifo_full_i, rx_fifo_empty_i, r_tx_wr_err, r_rx_rd_err};
            c_ADDR_LDVR: w_rdata = r_ldvr;
            c_ADDR_UDVR: w_rdata = r_udvr;
            c_ADDR_FSR:  w_rdata = {2'b00, r_thr};
            c_ADDR_CTR:  w_rdata = {1'b0, r_ctr};
            c_ADDR_ISR:  w_rdata = {1'b0, r_ien, w_id, 1'b0};
            c_ADDR_RXR:  w_rdata = rx_fifo_empty_i ? 8'h00 : data_rx_i;
            default:     w_rdata = 8'h00;
        endcase
    end

    assign ireq_n_o      = r_ireq_n;
    assign divisor_o     = {r_udvr, r_ldvr};
    assign data_width_o  = r_ctr[1:0];
    assign stop_bits_o   = r_ctr[2];
    assign parity_mode_o = r_ctr[4:3];
    assign rx_stream_o   = r_ctr[5];
    assign tx_stream_o   = r_ctr[6];
    assign threshold_o   = r_thr;

endmodule

`default_nettype wire

// File: tb/tb_uart_host_interface.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_host_interface
// Brief   : Randomised bench for uart_host_interface against a register-level model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_host_interface;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ireq_n_o;
    logic [15:0] divisor_o;
    logic [1:0]  data_width_o;
    logic        stop_bits_o;
    logic [1:0]  parity_mode_o;
    logic        rx_stream_o;
    logic        tx_stream_o;
    logic [5:0]  threshold_o;
    logic [7:0]  tx_data_o;
    logic        tx_fifo_write_o;
    logic        rx_fifo_read_o;
    logic [7:0]  data_rx_i;
    logic        rx_fifo_empty_i, rx_fifo_full_i, tx_fifo_empty_i, tx_fifo_full_i;
    logic        rx_idle_i, tx_idle_i;
    logic        tx_done_i, overrun_error_i, frame_error_i, parity_error_i;

    logic        r_drv;
    logic [7:0]  r_wdata;
    wire  [7:0]  data_io;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: register contents as the host sees them.
    logic [7:0] m_ldvr, m_udvr;
    logic [6:0] m_ctr;
    logic [5:0] m_thr;
    logic [2:0] m_en;
    logic       m_errp, m_txdp, m_txerr, m_rxerr;

    always #5 clk_i = ~clk_i;

    uart_host_interface_if bus();

    assign data_io = r_drv ? r_wdata : 8'hzz;

    uart_host_interface dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .host            (bus),
        .data_io         (data_io),
        .ireq_n_o        (ireq_n_o),
        .divisor_o       (divisor_o),
        .data_width_o    (data_width_o),
        .stop_bits_o     (stop_bits_o),
        .parity_mode_o   (parity_mode_o),
        .rx_stream_o     (rx_stream_o),
        .tx_stream_o     (tx_stream_o),
        .threshold_o     (threshold_o),
        .tx_data_o       (tx_data_o),
        .tx_fifo_write_o (tx_fifo_write_o),
        .rx_fifo_read_o  (rx_fifo_read_o),
        .data_rx_i       (data_rx_i),
        .rx_fifo_empty_i (rx_fifo_empty_i),
        .rx_fifo_full_i  (rx_fifo_full_i),
        .tx_fifo_empty_i (tx_fifo_empty_i),
        .tx_fifo_full_i  (tx_fifo_full_i),
        .rx_idle_i       (rx_idle_i),
        .tx_idle_i       (tx_idle_i),
        .tx_done_i       (tx_done_i),
        .overrun_error_i (overrun_error_i),
        .frame_error_i   (frame_error_i),
        .parity_error_i  (parity_error_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_id();
        if (m_en[2] && m_errp)           return 3'd1;
        if (m_en[1] && !rx_fifo_empty_i) return 3'd2;
        if (m_en[0] && m_txdp)           return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {tx_idle_i, rx_idle_i, tx_fifo_full_i, tx_fifo_empty_i,
                          rx_fifo_full_i, rx_fifo_empty_i, m_txerr, m_rxerr};
            3'd1: return m_ldvr;
            3'd2: return m_udvr;
            3'd3: return {2'b00, m_thr};
            3'd4: return {1'b0, m_ctr};
            3'd5: return {1'b0, m_en, m_id(), 1'b0};
            3'd6: return rx_fifo_empty_i ? 8'h00 : data_rx_i;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_ldvr = 8'd26; m_udvr = 8'd0; m_ctr = 7'h03; m_thr = 6'd0; m_en = 3'b000;
        m_errp = 1'b0; m_txdp = 1'b0; m_txerr = 1'b0; m_rxerr = 1'b0;
    endtask

    task automatic check_cfg();
        chk("divisor",   32'(divisor_o),     32'({m_udvr, m_ldvr}));
        chk("dwidth",    32'(data_width_o),  32'(m_ctr[1:0]));
        chk("stop",      32'(stop_bits_o),   32'(m_ctr[2]));
        chk("parity",    32'(parity_mode_o), 32'(m_ctr[4:3]));
        chk("rxstream",  32'(rx_stream_o),   32'(m_ctr[5]));
        chk("txstream",  32'(tx_stream_o),   32'(m_ctr[6]));
        chk("threshold", 32'(threshold_o),   32'(m_thr));
    endtask

    task automatic check_irq(input string tag);
        @(posedge clk_i); #1;
        chk(tag, 32'(ireq_n_o), 32'(m_id() == 3'd0));
    endtask

    // One host transaction; cs is released afterwards for a full cycle.
    task automatic do_op(input logic rw, input logic [2:0] a, input logic [7:0] wd,
                         input logic evt_txd, output logic [7:0] rd);
        logic [2:0] id_now;
        logic [7:0] exp_rd;
        logic       push, pop;
        logic [7:0] txd;
        @(negedge clk_i);
        bus.chip_sel_n = 1'b0; bus.address = a; bus.read_write = rw;
        r_drv = !rw; r_wdata = wd; tx_done_i = evt_txd;
        #4;
        rd = data_io; push = tx_fifo_write_o; pop = rx_fifo_read_o; txd = tx_data_o;
        id_now = m_id();
        exp_rd = m_read(a);
        @(posedge clk_i); #1;
        tx_done_i = 1'b0;
        @(negedge clk_i);
        bus.chip_sel_n = 1'b1; r_drv = 1'b0;
        if (rw) chk($sformatf("read[%0d]", a), 32'(rd), 32'(exp_rd));
        chk("push", 32'(push), 32'(!rw && a == 3'd7 && !tx_fifo_full_i));
        chk("pop",  32'(pop),  32'(rw && a == 3'd6 && !rx_fifo_empty_i));
        if (push) chk("tx_data", 32'(txd), 32'(wd));
        if (rw) begin
            if (a == 3'd0) begin m_txerr = 1'b0; m_rxerr = 1'b0; end
            if (a == 3'd6 && rx_fifo_empty_i) m_rxerr = 1'b1;
        end else begin
            case (a)
                3'd1: m_ldvr = wd;
                3'd2: m_udvr = wd;
                3'd3: m_thr  = wd[5:0];
                3'd4: m_ctr  = wd[6:0];
                3'd5: begin
                    if (wd[0] && id_now == 3'd1) m_errp = 1'b0;
                    if (wd[0] && id_now == 3'd3) m_txdp = 1'b0;
                    m_en = wd[6:4];
                end
                3'd7: if (tx_fifo_full_i) m_txerr = 1'b1;
                default: ;
            endcase
        end
        if (evt_txd) m_txdp = 1'b1;
        check_cfg();
        check_irq("ireq_op");
    endtask

    task automatic pulse(input logic ovr, input logic frm, input logic par, input logic txd);
        @(negedge clk_i);
        overrun_error_i = ovr; frame_error_i = frm; parity_error_i = par; tx_done_i = txd;
        @(negedge clk_i);
        overrun_error_i = 1'b0; frame_error_i = 1'b0; parity_error_i = 1'b0; tx_done_i = 1'b0;
        if (ovr || frm || par) m_errp = 1'b1;
        if (txd) m_txdp = 1'b1;
        check_irq("ireq_evt");
    endtask

    task automatic apply_reset();
        bus.chip_sel_n = 1'b1;
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        model_reset();
        rst_n_i = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int cnt;
        logic [7:0] cap;
        bus.chip_sel_n = 1'b1; bus.address = 3'd0; bus.read_write = 1'b1;
        r_drv = 1'b0; r_wdata = 8'h00; data_rx_i = 8'h00;
        rx_fifo_empty_i = 1'b1; rx_fifo_full_i = 1'b0; tx_fifo_empty_i = 1'b1; tx_fifo_full_i = 1'b0;
        rx_idle_i = 1'b1; tx_idle_i = 1'b1;
        tx_done_i = 1'b0; overrun_error_i = 1'b0; frame_error_i = 1'b0; parity_error_i = 1'b0;
        apply_reset();
        #1;
        check_cfg();
        chk("rst_ireq", 32'(ireq_n_o), 32'd1);
        chk("rst_push", 32'(tx_fifo_write_o), 32'd0);
        chk("rst_pop",  32'(rx_fifo_read_o), 32'd0);

        // Divisor bytes
        do_op(1'b0, 3'd1, 8'h1A, 1'b0, rd);
        do_op(1'b0, 3'd2, 8'h00, 1'b0, rd);
        chk("div26", 32'(divisor_o), 32'd26);
        do_op(1'b1, 3'd1, 8'h00, 1'b0, rd);
        chk("ldvr_rb", 32'(rd), 32'h1A);

        // Long chip select gives a single push
        @(negedge clk_i);
        bus.chip_sel_n = 1'b0; bus.address = 3'd7; bus.read_write = 1'b0;
        r_drv = 1'b1; r_wdata = 8'h48; cnt = 0; cap = 8'h00;
        repeat (3) begin
            #4;
            if (tx_fifo_write_o === 1'b1) begin cnt++; cap = tx_data_o; end
            @(negedge clk_i);
        end
        bus.chip_sel_n = 1'b1; r_drv = 1'b0;
        chk("long_cs_pushes", 32'(cnt), 32'd1);
        chk("long_cs_data", 32'(cap), 32'h48);

        // Write to a full TX FIFO, sticky error cleared by STR read
        tx_fifo_full_i = 1'b1; tx_fifo_empty_i = 1'b0;
        do_op(1'b0, 3'd7, 8'hA5, 1'b0, rd);
        do_op(1'b1, 3'd0, 8'h00, 1'b0, rd);
        chk("str_txerr_set", 32'(rd[1]), 32'd1);
        do_op(1'b1, 3'd0, 8'h00, 1'b0, rd);
        chk("str_txerr_clr", 32'(rd[1]), 32'd0);
        tx_fifo_full_i = 1'b0; tx_fifo_empty_i = 1'b1;

        // TX done interrupt and ack
        do_op(1'b0, 3'd5, 8'h70, 1'b0, rd);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("txd_ireq", 32'(ireq_n_o), 32'd0);
        do_op(1'b1, 3'd5, 8'h00, 1'b0, rd);
        chk("isr_76", 32'(rd), 32'h76);
        do_op(1'b0, 3'd5, 8'h77, 1'b0, rd);
        chk("ack_ireq", 32'(ireq_n_o), 32'd1);

        // Ack racing a new tx_done pulse: pending stays set
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        do_op(1'b0, 3'd5, 8'h71, 1'b1, rd);
        chk("race_ireq", 32'(ireq_n_o), 32'd0);
        do_op(1'b0, 3'd5, 8'h71, 1'b0, rd);

        // Error beats RXD; RXR read pops
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        rx_fifo_empty_i = 1'b0; data_rx_i = 8'h55;
        do_op(1'b1, 3'd5, 8'h00, 1'b0, rd);
        chk("isr_err_id", 32'(rd[3:1]), 32'd1);
        do_op(1'b0, 3'd5, 8'h71, 1'b0, rd);
        do_op(1'b1, 3'd5, 8'h00, 1'b0, rd);
        chk("isr_rxd_id", 32'(rd[3:1]), 32'd2);
        do_op(1'b1, 3'd6, 8'h00, 1'b0, rd);
        chk("rxr_55", 32'(rd), 32'h55);
        rx_fifo_empty_i = 1'b1;
        do_op(1'b1, 3'd6, 8'h00, 1'b0, rd);
        do_op(1'b1, 3'd0, 8'h00, 1'b0, rd);
        chk("str_rxerr", 32'(rd[0]), 32'd1);

        // Reset in the middle of a CTR write, then a held select
        do_op(1'b0, 3'd4, 8'h5C, 1'b0, rd);
        @(negedge clk_i);
        bus.chip_sel_n = 1'b0; bus.address = 3'd4; bus.read_write = 1'b0;
        r_drv = 1'b1; r_wdata = 8'h7F;
        #2 rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        model_reset();
        chk("rst_mid_ctr", 32'({stop_bits_o, data_width_o}), 32'h3);
        rst_n_i = 1'b1;
        cnt = 0;
        repeat (2) @(negedge clk_i);
        bus.address = 3'd7;
        repeat (2) begin
            #4;
            if (tx_fifo_write_o === 1'b1) cnt++;
            @(negedge clk_i);
        end
        bus.chip_sel_n = 1'b1; r_drv = 1'b0;
        chk("held_cs_push", 32'(cnt), 32'd0);
        check_cfg();
        do_op(1'b0, 3'd4, 8'h7F, 1'b0, rd);

        // Randomised traffic
        for (int it = 0; it < 300; it++) begin
            logic [3:0] k;
            rx_fifo_empty_i = 1'($urandom_range(0, 1));
            rx_fifo_full_i  = 1'($urandom_range(0, 1));
            tx_fifo_empty_i = 1'($urandom_range(0, 1));
            tx_fifo_full_i  = 1'($urandom_range(0, 1));
            rx_idle_i       = 1'($urandom_range(0, 1));
            tx_idle_i       = 1'($urandom_range(0, 1));
            data_rx_i       = 8'($urandom);
            k = 4'($urandom_range(0, 9));
            if (k < 4)
                do_op(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 1'b0, rd);
            else if (k < 8)
                do_op(1'b1, 3'($urandom_range(0, 7)), 8'h00, 1'b0, rd);
            else if (k == 8)
                pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                do_op(1'($urandom_range(0, 1)), 3'($urandom_range(6, 7)), 8'($urandom),
                      1'($urandom_range(0, 1)), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
